rv32i_mc_ctrl: RTL
==================

// Module: rv32i_mc_ctrl
// PURPOSE
//  Multi-cycle RV32I control FSM: the initiator that drives the ALU's a/b select and 4-bit ALUctrl.
//  Fetches over a req/valid memory handshake, latches the IR, sequences EXEC/MEM/WB per opcode.
//  Resolves branches from the ALU result. Sits beside the datapath (PC, regfile, ALUOut, memory mux).
// PARAMETERS
//  MEM_WAIT_MAX  16  cycles without mem_valid_i before timeout_o sets (0 = no timeout)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  mem_rdata_i   in   32  memory read data (instruction in FETCH, load data in MEM)
//  mem_valid_i   in   1   memory response/ack for the current request
//  alu_res_i     in   32  ALU result_o, for branch decisions
//  mem_req_o     out  1   memory request, held until mem_valid_i
//  mem_we_o      out  1   store strobe, qualified by mem_req_o
//  mem_addr_sel_o out 1   0 = PC, 1 = ALUOut register
//  ir_o          out  32  latched instruction
//  alu_ctrl_o    out  4   0 ADD,1 SUB,2 SLL,3 SLT,4 XOR,5 SLTU,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B
//  alu_a_sel_o   out  1   0 = rs1, 1 = PC
//  alu_b_sel_o   out  1   0 = rs2, 1 = immediate
//  aluout_we_o   out  1   capture alu_res into ALUOut
//  rf_we_o       out  1   regfile write (datapath forces x0 ignore)
//  wb_sel_o      out  2   0 = ALUOut, 1 = mem_rdata, 2 = PC+4
//  pc_we_o       out  1   PC update
//  pc_sel_o      out  1   0 = PC+4 (datapath adder), 1 = ALUOut (JALR lsb cleared in datapath)
//  illegal_o     out  1   sticky: unsupported opcode/funct decoded
//  timeout_o     out  1   sticky: memory wait exceeded MEM_WAIT_MAX
// BEHAVIOUR
//  Reset: state=FETCH; ir_o=0; all strobes/selects 0; alu_ctrl_o=ADD; sticky flags 0.
//  Reset mid-op: abandon the access at once; mem_req_o drops asynchronously; no pc/rf write.
//  Handshake: in FETCH/MEM, mem_req_o stays 1 until the cycle mem_valid_i=1 (accept at that edge).
//   mem_valid_i with mem_req_o=0 is ignored. Address/we stable while req is high.
//  States and transitions:
//   FETCH  req, addr=PC; on valid: ir<=mem_rdata_i -> DECODE
//   DECODE classify opcode; illegal -> TRAP; else -> EXEC
//   EXEC   OP: funct-decoded op a=rs1 b=rs2. OP-IMM: b=imm; SUB never for imm (funct7 ignored
//           except SRAI). LOAD/STORE/JALR: ADD rs1+imm. JAL/AUIPC: ADD PC+imm.
//           LUI: PASS_B imm. BRANCH: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU, a=rs1 b=rs2.
//           aluout_we=1 for all except BRANCH, where taken<=cond(alu_res_i):
//           BEQ res==0, BNE res!=0, BLT/BLTU res[0], BGE/BGEU !res[0]
//           Next: LOAD/STORE -> MEM; BRANCH -> BR; else -> WB
//   MEM    req, addr_sel=1, we=STORE. On valid: STORE -> FETCH with pc_we, pc_sel=0;
//           LOAD latches load data (datapath MDR) -> WB
//   BR     ADD PC+imm; pc_we=1, pc_sel=0, aluout bypass: datapath takes alu_res when taken -> FETCH
//   WB     rf_we=1, wb_sel per class (LOAD 1, JAL/JALR 2, else 0); pc_we=1,
//           pc_sel=1 for JAL/JALR else 0 -> FETCH
//   TRAP   all strobes 0; illegal_o=1; held until rst
//  Latency, zero-wait memory: ALU/LUI/AUIPC/JAL 4 cyc, BRANCH 4, STORE 4, LOAD 5.
//  Timeout: wait counter saturates; at MEM_WAIT_MAX set timeout_o, remain waiting (no abort).
//  Exactly one pc_we pulse per retired instruction; rf_we never with pc_we in non-WB state.
// STRUCTURE
//  rv32i_pkg: alu_op_e (values above), opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH,
//   JAL, JALR, LUI, AUIPC), ctrl_state_e, wb_sel_e.
//  Sub-module alu_dec: combinational opcode/funct3/funct7 -> alu_op_e + illegal flag.
// TESTING
//  rst held then released, mem_valid_i=1 -> FETCH, req=1 addr_sel=0, one pc_we per instruction.
//  add x3,x1,x2 (0x002081B3) -> EXEC alu_ctrl=0; sub (0x402081B3) alu_ctrl=1; WB rf_we wb_sel=0.
//  beq, alu_res_i=0 in EXEC -> BR pc_sel=0, datapath target taken; alu_res_i=5 -> not taken.
//  lw (0x0000A183), mem_valid delayed 3 cycles -> req held 4 cycles, WB wb_sel=1, total 8 cycles.
//  opcode 0x7F -> TRAP, illegal_o=1, no pc_we/rf_we until rst; rst recovers to FETCH.
//  rst asserted in MEM of a store -> mem_req_o/mem_we_o drop same cycle; restarts in FETCH.

Source files
------------

// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller: ALU op codes, opcodes, FSM states,
// write-back selects and the small decode helpers used by the controller and its decoder.
package rv32i_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLTU   = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BR, S_WB, S_TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MEM    = 2'd1,
    WB_PC4    = 2'd2
  } wb_sel_e;

  // alt selects the SUB/SRA flavour of the shared funct3 groups
  function automatic alu_op_e funct3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] res);
    logic tk;
    case (f3)
      3'b000:         tk = (res == 32'd0);
      3'b001:         tk = (res != 32'd0);
      3'b100, 3'b110: tk = res[0];
      default:        tk = ~res[0];
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Memory request/response handshake between the controller (master) and the memory side.
interface rv32i_mc_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_rdata, mem_valid);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_rdata, mem_valid);
endinterface

// File: rtl/rv32i_mc_ctrl_alu_dec.sv
// Combinational decode of opcode/funct3/funct7 into the ALU operation for EXEC,
// flagging any encoding the controller does not support.
module rv32i_mc_ctrl_alu_dec
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        if (funct7_i == 7'b0000000) begin
          alu_op_o = funct3_to_op(funct3_i, 1'b0);
        end else if (funct7_i == 7'b0100000 && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
          alu_op_o = funct3_to_op(funct3_i, 1'b1);
        end else begin
          illegal_o = 1'b1;
        end
      end
      // immediates never subtract; only the shift-right group looks at funct7
      OPC_OP_IMM: alu_op_o = funct3_to_op(funct3_i, (funct3_i == 3'b101) && funct7_i[5]);
      OPC_LOAD:   illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      OPC_STORE:  illegal_o = funct3_i[2] || (funct3_i == 3'b011);
      OPC_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: alu_op_o = ALU_SUB;
          3'b100, 3'b101: alu_op_o = ALU_SLT;
          3'b110, 3'b111: alu_op_o = ALU_SLTU;
          default:        illegal_o = 1'b1;
        endcase
      end
      OPC_JALR:            illegal_o = (funct3_i != 3'b000);
      OPC_JAL, OPC_AUIPC:  alu_op_o = ALU_ADD;
      OPC_LUI:             alu_op_o = ALU_PASS_B;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetches over the req/valid handshake, latches the IR and
// sequences EXEC/MEM/BR/WB, steering the datapath selects and strobes.
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32i_mc_ctrl_if.master        mem,
  input  logic [31:0]            alu_res_i,
  output logic [31:0]            ir_o,
  output logic [3:0]             alu_ctrl_o,
  output logic                   alu_a_sel_o,
  output logic                   alu_b_sel_o,
  output logic                   aluout_we_o,
  output logic                   rf_we_o,
  output logic [1:0]             wb_sel_o,
  output logic                   pc_we_o,
  output logic                   pc_sel_o,
  output logic                   illegal_o,
  output logic                   timeout_o
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  ctrl_state_e       state_q, state_d;
  logic [31:0]       ir_q;
  logic              taken_q, illegal_q, timeout_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              req_d, we_d, addr_sel_d, ir_we;
  alu_op_e           dec_op;
  logic              dec_illegal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_op, is_branch, is_load, is_store, is_jal, is_jalr, is_auipc;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_auipc  = (opcode == OPC_AUIPC);

  rv32i_mc_ctrl_alu_dec u_alu_dec (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (ir_q[31:25]),
    .alu_op_o  (dec_op),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= mem.mem_rdata;
      if (state_q == S_EXEC) taken_q <= branch_taken(funct3, alu_res_i);
      if (state_q == S_DECODE && dec_illegal) illegal_q <= 1'b1;
      // consecutive unanswered request cycles; the access keeps waiting after timeout
      if (req_d && !mem.mem_valid) begin
        if (wait_cnt_q != WAIT_SAT) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        if (MEM_WAIT_MAX != 0 && wait_cnt_q == WAIT_LAST) timeout_q <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = 1'b0;
    we_d        = 1'b0;
    addr_sel_d  = 1'b0;
    ir_we       = 1'b0;
    alu_ctrl_o  = ALU_ADD;
    alu_a_sel_o = 1'b0;
    alu_b_sel_o = 1'b0;
    aluout_we_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = WB_ALUOUT;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (mem.mem_valid) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alu_ctrl_o  = dec_op;
        alu_a_sel_o = is_jal || is_auipc;
        alu_b_sel_o = !(is_op || is_branch);
        aluout_we_o = !is_branch;
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_BR;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        req_d      = 1'b1;
        addr_sel_d = 1'b1;
        we_d       = is_store;
        if (mem.mem_valid) begin
          pc_we_o = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end
      end
      // target PC+imm; the ALUOut strobe tells the datapath to take it on a taken branch
      S_BR: begin
        alu_a_sel_o = 1'b1;
        alu_b_sel_o = 1'b1;
        pc_we_o     = 1'b1;
        aluout_we_o = taken_q;
        state_d     = S_FETCH;
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        pc_sel_o = is_jal || is_jalr;
        if (is_load)                wb_sel_o = WB_MEM;
        else if (is_jal || is_jalr) wb_sel_o = WB_PC4;
        else                        wb_sel_o = WB_ALUOUT;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // reset withdraws any outstanding access immediately, not at the next edge
  assign mem.mem_req      = req_d & ~rst;
  assign mem.mem_we       = we_d & ~rst;
  assign mem.mem_addr_sel = addr_sel_d & ~rst;

  assign ir_o      = ir_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

endmodule
